lutram_cfg_ctrl: RTL

LUTRAM_CFG_CTRL -- requirements
Module: lutram_cfg_ctrl

---
 rtl/lutram_cfg_ctrl_pkg.sv | 30 +++
 rtl/lutram_cfg_ctrl_if.sv | 47 ++++
 rtl/lutram_cfg_addr_cnt.sv | 27 ++
 rtl/lutram_cfg_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/lutram_cfg_ctrl_pkg.sv
// Shared definitions for the LUTRAM configuration controller.
// Optional readback verification is compiled in with LUTRAM_CFG_VERIFY_EN.
package lutram_cfg_ctrl_pkg;

   localparam int DEF_NUM_LUTS = 8;
   localparam int DEF_K        = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WRITE,
`ifdef LUTRAM_CFG_VERIFY_EN
      ST_VERIFY,
`endif
      ST_DONE
   } state_t;

   // Cycles from the start request through the cfg_done pulse, both inclusive,
   // when cfg_data is offered as soon as the controller asks for it.
   function automatic int cfg_latency(input int num_luts, input int k);
`ifdef LUTRAM_CFG_VERIFY_EN
      return num_luts * ((2 ** k) + 1) + 2 + num_luts * (2 ** k);
`else
      return num_luts * ((2 ** k) + 1) + 2;
`endif
   endfunction

   localparam int CFG_LATENCY = cfg_latency(DEF_NUM_LUTS, DEF_K);

endpackage

// File: rtl/lutram_cfg_ctrl_if.sv
// Bus between the configuration source, the controller and the LUTRAM array.
// Readback ports exist only when LUTRAM_CFG_VERIFY_EN is defined.
interface lutram_cfg_ctrl_if
   import lutram_cfg_ctrl_pkg::*;
#(
   parameter int NUM_LUTS = DEF_NUM_LUTS,
   parameter int K        = DEF_K
);

   logic                  start;
   logic [(2**K)-1:0]     cfg_data;
   logic                  cfg_valid;
   logic                  cfg_ready;
   logic [K-1:0]          lut_a;
   logic                  lut_d;
   logic [NUM_LUTS-1:0]   lut_we;
   logic                  busy;
   logic                  cfg_done;
`ifdef LUTRAM_CFG_VERIFY_EN
   logic [K-1:0]          lut_dpra;
   logic [NUM_LUTS-1:0]   lut_dpo;
   logic                  cfg_error;
`endif

`ifdef LUTRAM_CFG_VERIFY_EN
   modport master (
      output start, cfg_data, cfg_valid, lut_dpo,
      input  cfg_ready, lut_a, lut_d, lut_we, busy, cfg_done, lut_dpra, cfg_error
   );

   modport slave (
      input  start, cfg_data, cfg_valid, lut_dpo,
      output cfg_ready, lut_a, lut_d, lut_we, busy, cfg_done, lut_dpra, cfg_error
   );
`else
   modport master (
      output start, cfg_data, cfg_valid,
      input  cfg_ready, lut_a, lut_d, lut_we, busy, cfg_done
   );

   modport slave (
      input  start, cfg_data, cfg_valid,
      output cfg_ready, lut_a, lut_d, lut_we, busy, cfg_done
   );
`endif

endinterface

// File: rtl/lutram_cfg_addr_cnt.sv
// K-bit LUTRAM address counter; tc flags the last address so the
// controller knows the next increment wraps back to zero.
module lutram_cfg_addr_cnt
   import lutram_cfg_ctrl_pkg::*;
#(
   parameter int K = DEF_K
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         enable,
   output logic [K-1:0] addr,
   output logic         tc
);

   // Clear wins over enable so a fresh LUT always starts at address zero.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         addr <= '0;
      end else if (enable) begin
         addr <= addr + K'(1);
      end
   end

   assign tc = &addr;

endmodule

// File: rtl/lutram_cfg_ctrl.sv
// Sequences NUM_LUTS LUTRAMs: takes one truth table per LUT and serialises
// it into 2**K single-bit write strobes. Defining LUTRAM_CFG_VERIFY_EN adds
// a readback pass per LUT that raises a sticky cfg_error on any mismatch.
module lutram_cfg_ctrl
   import lutram_cfg_ctrl_pkg::*;
#(
   parameter int NUM_LUTS = DEF_NUM_LUTS,
   parameter int K        = DEF_K
) (
   input logic              clk,
   input logic              rst,
   lutram_cfg_ctrl_if.slave bus
);

   localparam int DEPTH = 2 ** K;
   localparam int IDX_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LUTS - 1);

   state_t             state_q;
   state_t             state_d;
   logic [IDX_W-1:0]   lut_idx_q;
   logic [IDX_W-1:0]   lut_idx_d;
   logic [DEPTH-1:0]   shadow_q;
   logic               load_shadow;
   logic               cnt_clear;
   logic               cnt_en;
   logic [K-1:0]       addr;
   logic               addr_tc;
`ifdef LUTRAM_CFG_VERIFY_EN
   logic               cfg_error_q;
   logic               err_set;
`endif

   lutram_cfg_addr_cnt #(
      .K (K)
   ) u_addr_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .addr   (addr),
      .tc     (addr_tc)
   );

   // State, current LUT index and the captured truth table; reset beats everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         lut_idx_q <= '0;
         shadow_q  <= '0;
`ifdef LUTRAM_CFG_VERIFY_EN
         cfg_error_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         lut_idx_q <= lut_idx_d;
         if (load_shadow) begin
            shadow_q <= bus.cfg_data;
         end
`ifdef LUTRAM_CFG_VERIFY_EN
         if (err_set) begin
            cfg_error_q <= 1'b1;
         end
`endif
      end
   end

`ifdef LUTRAM_CFG_VERIFY_EN
   assign bus.cfg_error = cfg_error_q;
`endif

   // Next-state and Moore outputs; every output idles at zero outside its own state.
   always_comb begin
      state_d       = state_q;
      lut_idx_d     = lut_idx_q;
      load_shadow   = 1'b0;
      cnt_clear     = 1'b0;
      cnt_en        = 1'b0;
      bus.cfg_ready = 1'b0;
      bus.lut_a     = '0;
      bus.lut_d     = 1'b0;
      bus.lut_we    = '0;
      bus.busy      = (state_q != ST_IDLE);
      bus.cfg_done  = 1'b0;
`ifdef LUTRAM_CFG_VERIFY_EN
      bus.lut_dpra  = '0;
      err_set       = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               lut_idx_d = '0;
               state_d   = ST_LOAD;
            end
         end

         ST_LOAD: begin
            bus.cfg_ready = 1'b1;
            if (bus.cfg_valid) begin
               load_shadow = 1'b1;
               cnt_clear   = 1'b1;
               state_d     = ST_WRITE;
            end
         end

         ST_WRITE: begin
            bus.lut_a  = addr;
            bus.lut_d  = shadow_q[addr];
            bus.lut_we = NUM_LUTS'(1) << lut_idx_q;
            cnt_en     = 1'b1;
            if (addr_tc) begin
`ifdef LUTRAM_CFG_VERIFY_EN
               state_d = ST_VERIFY;
`else
               if (lut_idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  lut_idx_d = lut_idx_q + IDX_W'(1);
                  state_d   = ST_LOAD;
               end
`endif
            end
         end

`ifdef LUTRAM_CFG_VERIFY_EN
         ST_VERIFY: begin
            bus.lut_dpra = addr;
            cnt_en       = 1'b1;
            if (bus.lut_dpo[lut_idx_q] != shadow_q[addr]) begin
               err_set = 1'b1;
            end
            if (addr_tc) begin
               if (lut_idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  lut_idx_d = lut_idx_q + IDX_W'(1);
                  state_d   = ST_LOAD;
               end
            end
         end
`endif

         ST_DONE: begin
            bus.cfg_done = 1'b1;
            state_d      = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
